// File: rtl/nes_joypad_port_pkg.sv
// Shared constants for the NES controller-port emulation: SNES-style pad word
// layout, NES report bit order and the "no controller" marker.
package nes_joypad_port_pkg;

  localparam int PAD_W    = 12;
  localparam int REPORT_W = 8;

  typedef logic [PAD_W-1:0]    pad_word_t;
  typedef logic [REPORT_W-1:0] nes_report_t;

  localparam pad_word_t PAD_ABSENT = 12'hfff;

  // Bit positions in the SNES-style pad word (1 = pressed).
  localparam int SNES_B      = 11;
  localparam int SNES_Y      = 10;
  localparam int SNES_SELECT = 9;
  localparam int SNES_START  = 8;
  localparam int SNES_UP     = 7;
  localparam int SNES_DOWN   = 6;
  localparam int SNES_LEFT   = 5;
  localparam int SNES_RIGHT  = 4;
  localparam int SNES_A      = 3;
  localparam int SNES_X      = 2;
  localparam int SNES_L      = 1;
  localparam int SNES_R      = 0;

  // Bit positions in the NES report; bit 0 leaves the shift register first.
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  // Source pad bit for each NES report bit, indexed by NES bit position.
  localparam int NES_SRC_BIT [REPORT_W] = '{
    SNES_A, SNES_B, SNES_SELECT, SNES_START,
    SNES_UP, SNES_DOWN, SNES_LEFT, SNES_RIGHT
  };

endpackage

// File: rtl/nes_pad_shifter.sv
// One NES controller port: pad-word remap with turbo, 8-bit report shift
// register and the presence-dependent fill bit.
import nes_joypad_port_pkg::*;

module nes_pad_shifter (
  input  logic      clk,
  input  logic      rst,
  input  pad_word_t pad_state,
  input  logic      turbo_en,
  input  logic      phase,
  input  logic      strobe,
  input  logic      reload,
  input  logic      rd,
  output logic      serial_bit
);

  logic        present;
  logic        turbo_on;
  nes_report_t base_bits;
  nes_report_t mapped;
  nes_report_t shift_reg;
  nes_report_t shift_next;

  assign present  = (pad_state != PAD_ABSENT);
  assign turbo_on = turbo_en & phase;

  genvar gi;
  generate
    for (gi = 0; gi < REPORT_W; gi++) begin : g_map
      assign base_bits[gi] = pad_state[NES_SRC_BIT[gi]];
    end
  endgenerate

  // X and Y act as auto-fire A and B while the turbo phase is high.
  always_comb begin
    mapped = '0;
    if (present) begin
      mapped         = base_bits;
      mapped[NES_A]  = base_bits[NES_A] | (pad_state[SNES_X] & turbo_on);
      mapped[NES_B]  = base_bits[NES_B] | (pad_state[SNES_Y] & turbo_on);
    end
  end

  always_comb begin
    shift_next = shift_reg;
    if (reload) begin
      shift_next = mapped;
    end else if (rd) begin
      shift_next = {present, shift_reg[REPORT_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_next;
    end
  end

  // While strobing the port is transparent to the live A button.
  assign serial_bit = strobe ? mapped[NES_A] : shift_reg[0];

endmodule

// File: rtl/nes_joypad_port.sv
// Two 2A03 controller ports ($4016/$4017) fed by parallel SNES-style pad
// words: strobe latch, shared turbo timebase and CPU read mux.
import nes_joypad_port_pkg::*;

module nes_joypad_port #(
  parameter int TURBO_DIV = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pad1_state,
  input  logic [11:0] pad2_state,
  input  logic [1:0]  turbo_en,
  input  logic        strobe_wr,
  input  logic        strobe_data,
  input  logic [1:0]  rd_en,
  output logic [7:0]  rd_data,
  output logic        strobe
);

  localparam int CNT_W = (TURBO_DIV > 2) ? $clog2(TURBO_DIV) : 1;
  localparam logic [CNT_W-1:0] TURBO_LAST = CNT_W'(TURBO_DIV - 1);

  logic             strobe_reg;
  logic             strobe_next;
  logic [CNT_W-1:0] turbo_cnt_reg;
  logic [CNT_W-1:0] turbo_cnt_next;
  logic             phase_reg;
  logic             phase_next;
  logic             reload;
  pad_word_t        pad_state [2];
  logic [1:0]       serial_bit;

  assign pad_state[0] = pad1_state;
  assign pad_state[1] = pad2_state;

  assign strobe_next = strobe_wr ? strobe_data : strobe_reg;

  // A rising write reloads immediately; a falling write still reloads because
  // the latch is high during the write cycle.
  assign reload = strobe_reg | (strobe_wr & strobe_data);

  always_comb begin
    turbo_cnt_next = turbo_cnt_reg + 1'b1;
    phase_next     = phase_reg;
    if (turbo_cnt_reg == TURBO_LAST) begin
      turbo_cnt_next = '0;
      phase_next     = ~phase_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_reg    <= 1'b0;
      turbo_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else begin
      strobe_reg    <= strobe_next;
      turbo_cnt_reg <= turbo_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      nes_pad_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .pad_state  (pad_state[gi]),
        .turbo_en   (turbo_en[gi]),
        .phase      (phase_reg),
        .strobe     (strobe_reg),
        .reload     (reload),
        .rd         (rd_en[gi]),
        .serial_bit (serial_bit[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    case (rd_en)
      2'b01:   rd_data[0] = serial_bit[0];
      2'b10:   rd_data[0] = serial_bit[1];
      default: rd_data    = '0;
    endcase
  end

  assign strobe = strobe_reg;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port: a queue-of-bits controller model
// predicts every read; a negedge monitor compares.
module tb_nes_joypad_port;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pad1_state = '0;
  logic [11:0] pad2_state = '0;
  logic [1:0]  turbo_en = '0;
  logic        strobe_wr = 1'b0;
  logic        strobe_data = 1'b0;
  logic [1:0]  rd_en = '0;
  logic [7:0]  rd_data;
  logic        strobe;

  nes_joypad_port #(.TURBO_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .pad1_state  (pad1_state),
    .pad2_state  (pad2_state),
    .turbo_en    (turbo_en),
    .strobe_wr   (strobe_wr),
    .strobe_data (strobe_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .strobe      (strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    int         id;
    int         port;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   m_strobe = 1'b0;
  bit   q1[$];
  bit   q2[$];
  int   cyc = 0;
  int   txn = 0;

  // Controller report as the CPU sees it, built straight from button names.
  function automatic logic [7:0] ref_byte(logic [11:0] p, logic en, logic ph);
    logic a, b;
    if (p == 12'hfff) return 8'h00;
    a = p[3] | (p[2] & en & ph);
    b = p[11] | (p[10] & en & ph);
    return {p[4], p[5], p[6], p[7], p[8], p[9], b, a};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if (strobe !== m_strobe) begin
        failures++;
        $display("FAIL strobe_out t=%0t got=%b want=%b", $time, strobe, m_strobe);
      end
      checks++;
      if (rd_en != 2'b00) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL read_unexpected t=%0t rd_en=%b rd_data=%h want=none", $time, rd_en, rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e.val) begin
            failures++;
            $display("FAIL read txn=%0d port=%0d got=%h want=%h", e.id, e.port, rd_data, e.val);
          end else begin
            $display("read txn=%0d port=%0d rd_data=%h ok", e.id, e.port, rd_data);
          end
        end
      end else if (rd_data !== 8'h00) begin
        failures++;
        $display("FAIL idle_rd_data t=%0t got=%h want=00", $time, rd_data);
      end
    end
  end

  task automatic model_clear();
    q1.delete();
    q2.delete();
    repeat (8) begin
      q1.push_back(1'b0);
      q2.push_back(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    strobe_wr = 1'b0;
    rd_en = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_strobe = 1'b0;
    cyc = 0;
    model_clear();
    checks++;
    if (strobe !== 1'b0 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_state strobe=%b rd_data=%h want strobe=0 rd_data=00", strobe, rd_data);
    end
  endtask

  task automatic cycle(input logic sw, input logic sd, input logic [1:0] rd);
    logic [7:0] m1, m2;
    logic       ph, reload;
    exp_t       e;
    strobe_wr = sw;
    strobe_data = sd;
    rd_en = rd;
    ph = ((cyc / DIV) % 2) == 1;
    m1 = ref_byte(pad1_state, turbo_en[0], ph);
    m2 = ref_byte(pad2_state, turbo_en[1], ph);
    reload = m_strobe || (sw && sd);
    if (rd == 2'b01) begin
      e.val = {7'b0, m_strobe ? m1[0] : q1[0]};
      e.id = txn++;
      e.port = 1;
      exp_q.push_back(e);
    end else if (rd == 2'b10) begin
      e.val = {7'b0, m_strobe ? m2[0] : q2[0]};
      e.id = txn++;
      e.port = 2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (reload) begin
      q1.delete();
      q2.delete();
      for (int i = 0; i < 8; i++) begin
        q1.push_back(m1[i]);
        q2.push_back(m2[i]);
      end
    end else if (rd == 2'b01) begin
      void'(q1.pop_front());
      q1.push_back(pad1_state != 12'hfff);
    end else if (rd == 2'b10) begin
      void'(q2.pop_front());
      q2.push_back(pad2_state != 12'hfff);
    end
    if (sw) m_strobe = sd;
    cyc++;
    strobe_wr = 1'b0;
    strobe_data = 1'b0;
    rd_en = 2'b00;
  endtask

  task automatic latch();
    cycle(1'b1, 1'b1, 2'b00);
    cycle(1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    cycle(1'b0, 1'b0, 2'b00);

    // B+A on port 1: ten reads run past the end into the fill bits.
    pad1_state = 12'h808;
    pad2_state = 12'h0f0;
    latch();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 2'b01);

    // Absent controller on port 2.
    pad2_state = 12'hfff;
    latch();
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 2'b10);

    // Strobe held high: reads follow live A without shifting.
    pad2_state = 12'h123;
    cycle(1'b1, 1'b1, 2'b00);
    pad1_state = 12'h008;
    cycle(1'b0, 1'b0, 2'b01);
    pad1_state = 12'h800;
    cycle(1'b0, 1'b0, 2'b01);
    pad1_state = 12'h088;
    cycle(1'b0, 1'b0, 2'b01);
    cycle(1'b1, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 2'b01);
    cycle(1'b0, 1'b0, 2'b01);

    // Turbo on port 1 only, X held on both pads, strobe every cycle.
    turbo_en = 2'b01;
    pad1_state = 12'h004;
    pad2_state = 12'h004;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 2'b10);
    cycle(1'b1, 1'b0, 2'b00);
    turbo_en = 2'b00;

    // Collision: strobe write on the 4th read returns the pre-edge bit.
    pad1_state = 12'h2d8;
    latch();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b01);
    cycle(1'b1, 1'b1, 2'b01);
    cycle(1'b1, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 2'b01);
    cycle(1'b0, 1'b0, 2'b01);

    // Reset mid-sequence.
    pad1_state = 12'hfe8;
    latch();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b01);
    do_reset();
    cycle(1'b0, 1'b0, 2'b01);
    cycle(1'b0, 1'b0, 2'b01);

    // Randomised traffic: pads come and go, occasional strobes and turbo.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] rd;
      logic       sw;
      if ($urandom_range(0, 9) == 0)
        pad1_state = ($urandom_range(0, 4) == 0) ? 12'hfff : 12'($urandom);
      if ($urandom_range(0, 9) == 0)
        pad2_state = ($urandom_range(0, 4) == 0) ? 12'hfff : 12'($urandom);
      if ($urandom_range(0, 49) == 0) turbo_en = 2'($urandom);
      sw = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       rd = 2'b00;
        1:       rd = 2'b01;
        default: rd = 2'b10;
      endcase
      cycle(sw, 1'($urandom), rd);
    end

    cycle(1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 2'b00);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
